// File: rtl/my_demux_16_8_way_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_demux_pkg
// Purpose  : Shared constants, lane types and the lane-select decode helper
//            for the registered 16-bit 8-way demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package my_demux_pkg;

    localparam int LANES  = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] lane_t;
    typedef logic [LANES-1:0]  lane_mask_t;

    function automatic lane_mask_t sel_decode(input logic [SEL_W-1:0] s);
        lane_mask_t m;
        m    = '0;
        m[s] = 1'b1;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_demux_16_8_way_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : my_demux_16_8_way_reg_if
// Purpose  : Producer-side and lane-side bus of the 8-way demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
interface my_demux_16_8_way_reg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic [2:0]       sel;
    logic             in_ready;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic [WIDTH-1:0] out_e, out_f, out_g, out_h;
    logic [7:0]       out_valid;
    logic [7:0]       out_ack;

    modport master (
        output in, in_valid, sel, out_ack,
        input  in_ready, out_valid,
        input  out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h
    );

    modport slave (
        input  in, in_valid, sel, out_ack,
        output in_ready, out_valid,
        output out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h
    );
endinterface
`default_nettype wire

// File: rtl/my_demux_16_8_way_reg_lane.sv
`default_nettype none
// ============================================================================
// Module   : my_lane_reg_16
// Purpose  : One demux lane: holding register plus its valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module my_lane_reg_16 #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             wr_i,
    input  wire logic             ack_i,
    input  wire logic             clr_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o,
    output logic                  vld_o
);

    logic [WIDTH-1:0] data_q;
    logic             vld_q;

    // clr drops only the valid flag; held data survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
        end else if (wr_i) begin
            data_q <= d_i;
            vld_q  <= 1'b1;
        end else if (ack_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule
`default_nettype wire

// File: rtl/my_demux_16_8_way_reg.sv
`default_nettype none
// ============================================================================
// Module   : my_demux_16_8_way_reg
// Purpose  : Registered 16-bit 8-way demux with per-lane valid/ack handshake.
//            Define AUTO_SEL_EN for round-robin lane selection (sel ignored).
// Revision : 1.0 - initial release
// ============================================================================
module my_demux_16_8_way_reg
    import my_demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   clr,
    my_demux_16_8_way_reg_if.slave      bus
);

    logic [SEL_W-1:0] w_tgt;
    logic             w_ready;
    logic             w_accept;
    lane_mask_t       w_wr_mask;
    lane_mask_t       w_vld;
    logic [WIDTH-1:0] w_lane_q [LANES];

`ifdef AUTO_SEL_EN
    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // Counter only advances on accept, so a stalled lane holds it in place
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_tgt = cnt_q;
`else
    assign w_tgt = bus.sel;
`endif

    assign w_ready   = !bus.out_valid[w_tgt] | bus.out_ack[w_tgt];
    assign w_accept  = bus.in_valid & w_ready & !clr;
    assign w_wr_mask = w_accept ? sel_decode(w_tgt) : '0;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            my_lane_reg_16 #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .wr_i  (w_wr_mask[i]),
                .ack_i (bus.out_ack[i]),
                .clr_i (clr),
                .d_i   (bus.in),
                .q_o   (w_lane_q[i]),
                .vld_o (w_vld[i])
            );
        end
    endgenerate

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_vld;
    assign bus.out_a     = w_lane_q[0];
    assign bus.out_b     = w_lane_q[1];
    assign bus.out_c     = w_lane_q[2];
    assign bus.out_d     = w_lane_q[3];
    assign bus.out_e     = w_lane_q[4];
    assign bus.out_f     = w_lane_q[5];
    assign bus.out_g     = w_lane_q[6];
    assign bus.out_h     = w_lane_q[7];

endmodule
`default_nettype wire

// File: tb/tb_my_demux_16_8_way_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_demux_16_8_way_reg
// Purpose  : Self-checking bench: directed scenarios plus random traffic
//            against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_demux_16_8_way_reg;
    import my_demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    always #5 clk = ~clk;

    my_demux_16_8_way_reg_if #(.WIDTH(16)) bus ();

    my_demux_16_8_way_reg #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    lane_t      m_data [LANES];
    lane_mask_t m_vld;
    int         m_cnt;
    logic       last_rdy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic lane_t dut_lane(input int i);
        case (i)
            0: return bus.out_a;
            1: return bus.out_b;
            2: return bus.out_c;
            3: return bus.out_d;
            4: return bus.out_e;
            5: return bus.out_f;
            6: return bus.out_g;
            default: return bus.out_h;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) m_data[i] = '0;
        m_vld = '0;
        m_cnt = 0;
    endtask

    function automatic int model_tgt();
`ifdef AUTO_SEL_EN
        return m_cnt;
`else
        return int'(bus.sel);
`endif
    endfunction

    function automatic logic model_ready();
        int t;
        t = model_tgt();
        return !m_vld[t] || bus.out_ack[t];
    endfunction

    // Next lane state from the currently applied inputs
    task automatic model_edge();
        int   t;
        logic rdy;
        t   = model_tgt();
        rdy = model_ready();
        if (clr) begin
            m_vld = '0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < LANES; i++)
                if (bus.out_ack[i]) m_vld[i] = 1'b0;
            if (bus.in_valid && rdy) begin
                m_data[t] = bus.in;
                m_vld[t]  = 1'b1;
                m_cnt     = (m_cnt + 1) % LANES;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < LANES; i++)
            check_val($sformatf("%s lane%0d", tag, i), 32'(dut_lane(i)), 32'(m_data[i]));
        check_val({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_vld));
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle(input logic v, input logic [2:0] s, input lane_t d,
                         input lane_mask_t a, input logic c);
        bus.in_valid = v;
        bus.sel      = s;
        bus.in       = d;
        bus.out_ack  = a;
        clr          = c;
        #1;
        last_rdy = bus.in_ready;
        check_val("in_ready", 32'(bus.in_ready), 32'(model_ready()));
        model_edge();
        @(posedge clk);
        #1;
        compare_all("cycle");
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel      = '0;
        bus.in       = '0;
        bus.out_ack  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        check_val("reset in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef AUTO_SEL_EN
        for (int s = 0; s < LANES; s++)
            cycle(1'b1, 3'(s), lane_t'(16'h8000 >> (2 * s)), lane_mask_t'((1 << s) - 1), 1'b0);
        cycle(1'b0, 3'd0, 16'h0, 8'hFF, 1'b0);
        check_val("pat out_a", 32'(bus.out_a), 32'h8000);
        check_val("pat out_d", 32'(bus.out_d), 32'h0200);
        check_val("pat out_h", 32'(bus.out_h), 32'h0002);
        check_val("pat valid", 32'(bus.out_valid), 32'h00);

        cycle(1'b1, 3'd3, 16'h1234, 8'h00, 1'b0);
        cycle(1'b1, 3'd3, 16'h5678, 8'h00, 1'b0);
        check_val("full rdy", 32'(last_rdy), 32'd0);
        check_val("full out_d", 32'(bus.out_d), 32'h1234);
        check_val("full valid", 32'(bus.out_valid), 32'h08);
        cycle(1'b1, 3'd3, 16'h5678, 8'h08, 1'b0);
        check_val("refill rdy", 32'(last_rdy), 32'd1);
        check_val("refill out_d", 32'(bus.out_d), 32'h5678);
        check_val("refill valid", 32'(bus.out_valid), 32'h08);

        cycle(1'b0, 3'd0, 16'h0, 8'hFF, 1'b0);
        cycle(1'b1, 3'd5, 16'hA5A5, 8'h00, 1'b0);
        check_val("l5 valid", 32'(bus.out_valid), 32'h20);
        cycle(1'b1, 3'd2, 16'h0C0C, 8'h20, 1'b0);
        check_val("indep valid", 32'(bus.out_valid), 32'h04);

        for (int s = 0; s < LANES; s++)
            cycle(1'b1, 3'(s), lane_t'(16'h1100 + s), 8'h00, 1'b0);
        check_val("fill valid", 32'(bus.out_valid), 32'hFF);
        cycle(1'b1, 3'd0, 16'hDEAD, 8'h01, 1'b1);
        check_val("clr rdy", 32'(last_rdy), 32'd1);
        check_val("clr valid", 32'(bus.out_valid), 32'h00);
        check_val("clr out_a", 32'(bus.out_a), 32'h1100);
        check_val("clr out_h", 32'(bus.out_h), 32'h1107);
`else
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 3'($urandom), lane_t'(k), 8'hFB, 1'b0);
        check_val("auto out_a", 32'(bus.out_a), 32'd8);
        check_val("auto out_b", 32'(bus.out_b), 32'd9);
        check_val("auto out_c", 32'(bus.out_c), 32'd2);
        cycle(1'b1, 3'd0, 16'd10, 8'h00, 1'b0);
        check_val("stall rdy", 32'(last_rdy), 32'd0);
        cycle(1'b1, 3'd0, 16'd10, 8'h00, 1'b0);
        cycle(1'b1, 3'd0, 16'd10, 8'h04, 1'b0);
        check_val("stall rdy2", 32'(last_rdy), 32'd1);
        check_val("stall out_c", 32'(bus.out_c), 32'd10);
        check_val("stall out_d", 32'(bus.out_d), 32'd3);
`endif

        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 3) != 0, 3'($urandom), lane_t'($urandom),
                  lane_mask_t'($urandom), $urandom_range(0, 31) == 0);

        for (int s = 0; s < 4; s++)
            cycle(1'b1, 3'(s), lane_t'($urandom), 8'h00, 1'b0);
        bus.in_valid = 1'b1;
        bus.sel      = 3'd1;
        bus.out_ack  = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check_val("async_rst rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++)
            cycle($urandom_range(0, 3) != 0, 3'($urandom), lane_t'($urandom),
                  lane_mask_t'($urandom), $urandom_range(0, 31) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
